// File: rtl/mcu0_pkg.sv
// Shared MCU0 definitions: opcodes, datapath widths, fetch state encoding.
// MCU0_FETCH_ALIGN_CHECK_EN adds the FAULT state for misaligned redirects.
package mcu0_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_JMP = 4'd2;
  localparam logic [3:0] OP_ST  = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;
  localparam logic [3:0] OP_JEQ = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
    , FAULT
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] ir;
  } fetch_entry_t;

  // Next sequential instruction word; wraps naturally at the top of the 4K space.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(2);
  endfunction

endpackage

// File: rtl/mcu0_fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO of {pc, ir} with push, pop, flush and occupancy count.
module mcu0_fetch_fifo
  import mcu0_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [2:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !flush && (count < 3'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mcu0_fetch.sv
// MCU0 instruction fetch: single-outstanding memory requests into a prefetch FIFO.
// MCU0_FETCH_ALIGN_CHECK_EN enables the misaligned-redirect FAULT stop.
module mcu0_fetch
  import mcu0_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fault
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              squash_q, squash_d;

  logic              ack;
  logic              pop;
  logic              push;
  logic              flush;
  logic              halted;
  logic [ADDR_W-1:0] target;
  logic [3:0]        level;
  logic [2:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      wdata;

`ifdef MCU0_FETCH_ALIGN_CHECK_EN
  assign target = redirect_pc;
  assign halted = (state_q == FAULT);
  assign fault  = (state_q == FAULT);
`else
  logic unused_pc_bit0;
  assign unused_pc_bit0 = redirect_pc[0];
  assign target = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign halted = 1'b0;
  assign fault  = 1'b0;
`endif

  assign mem_rd   = (state_q == REQ);
  assign mem_addr = mem_rd ? pc_q : '0;
  assign ack      = mem_rd && mem_ack;

  assign ir_valid = (count != '0);
  assign ir       = ir_valid ? head.ir : '0;
  assign ir_pc    = ir_valid ? head.pc : '0;
  assign pop      = ir_valid && ir_ready;

  // Occupancy after this cycle's push and pop, used to decide whether to re-issue.
  assign level = 4'(count) + 4'd1 - 4'(pop);
  assign wdata = '{pc: pc_q, ir: mem_rdata};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    squash_d = squash_q;
    push     = 1'b0;
    flush    = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            pc_d     = tgt_q;
          end else begin
            push = 1'b1;
            pc_d = next_word(pc_q);
            if (level >= 4'(DEPTH)) state_d = FULL;
          end
        end
      end
      FULL: if (pop) state_d = REQ;
      default: state_d = state_q;
    endcase

    // Redirect overrides everything above. An in-flight request keeps mem_addr
    // until its ack arrives; the target waits in tgt_q meanwhile.
    if (redirect && !halted) begin
      flush = 1'b1;
      push  = 1'b0;
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
      if (redirect_pc[0]) begin
        state_d  = FAULT;
        squash_d = 1'b0;
      end else
`endif
      if (state_q == REQ && !ack) begin
        squash_d = 1'b1;
        tgt_d    = target;
        pc_d     = pc_q;
        state_d  = REQ;
      end else begin
        squash_d = 1'b0;
        pc_d     = target;
        state_d  = REQ;
      end
    end
  end

  mcu0_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (wdata),
    .head    (head),
    .count   (count)
  );

endmodule

// File: tb/tb_mcu0_fetch.sv
// Directed bench for mcu0_fetch: per-cycle vector table plus squash, wrap, reset and fault sequences.
module tb_mcu0_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [11:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        fault;

  logic        ack_auto;
  logic        ack_force;
  logic [15:0] mem [2048];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_ack   = ack_force || (ack_auto && mem_rd);
  assign mem_rdata = mem[mem_addr[11:1]];

  mcu0_fetch #(
    .RESET_PC(12'h000),
    .DEPTH(2)
  ) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault)
  );

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rd;
    logic [11:0] addr;
    logic        valid;
    logic [15:0] ir;
    logic [11:0] pc;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [63:0] outs();
    return {21'b0, fault, mem_rd, mem_addr, ir_valid, ir, ir_pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {4'h3, 12'(i * 2)};
    mem[0] = 16'h0010;
    mem[1] = 16'h1012;
    mem[2] = 16'h2000;

    //                rst ready rd  addr    valid ir        pc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 16'h0000, 12'h000};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 12'h002, 1'b1, 16'h0010, 12'h000};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 12'h004, 1'b1, 16'h1012, 12'h002};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 12'h006, 1'b1, 16'h2000, 12'h004};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 12'h008, 1'b1, 16'h3006, 12'h006};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 16'h0000, 12'h000};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 16'h0000, 12'h000};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 12'h002, 1'b1, 16'h0010, 12'h000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 16'h0010, 12'h000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 16'h0010, 12'h000};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 12'h004, 1'b1, 16'h1012, 12'h002};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 16'h1012, 12'h002};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 16'h1012, 12'h002};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 12'h006, 1'b1, 16'h2000, 12'h004};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 12'h008, 1'b1, 16'h3006, 12'h006};

    reset_n     = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ack_auto    = 1'b1;
    ack_force   = 1'b0;
    step();
    step();
    chk("reset_state", outs(), 64'h0);

    for (int i = 0; i < 17; i++) begin
      reset_n  = tbl[i].rst_n;
      ir_ready = tbl[i].ready;
      chk($sformatf("vec%0d", i), outs(),
          {21'b0, 1'b0, tbl[i].rd, tbl[i].addr, tbl[i].valid, tbl[i].ir, tbl[i].pc});
      step();
    end

    // Squash: redirect while the request at 004 is outstanding, ack three cycles late.
    ir_ready = 1'b1;
    do_reset();
    begin
      bit found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
        if (mem_rd && mem_addr == 12'h004) found = 1'b1;
        else step();
      end
      chk("reach_004", 64'(found), 64'd1);
    end
    ack_auto    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 12'h008;
    step();
    redirect = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("squash_hold%0d", n), {50'b0, mem_rd, mem_addr, ir_valid}, {50'b0, 1'b1, 12'h004, 1'b0});
      if (n < 2) step();
    end
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    chk("squash_next_addr", {50'b0, mem_rd, mem_addr, ir_valid}, {50'b0, 1'b1, 12'h008, 1'b0});
    ack_auto = 1'b1;
    step();
    chk("squash_first_ir", {35'b0, ir_valid, ir_pc, ir}, {35'b0, 1'b1, 12'h008, 16'h3008});

    // Wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 12'hFFE;
    step();
    redirect = 1'b0;
    chk("wrap_req", {50'b0, mem_rd, mem_addr, ir_valid}, {50'b0, 1'b1, 12'hFFE, 1'b0});
    step();
    chk("wrap_next", {22'b0, mem_rd, mem_addr, ir_valid, ir_pc, ir},
        {22'b0, 1'b1, 12'h000, 1'b1, 12'hFFE, 16'h3FFE});

    // Reset with a request outstanding; ack held high through reset and IDLE.
    ack_auto = 1'b0;
    step();
    chk("pre_reset_req", 64'(mem_rd), 64'd1);
    reset_n   = 1'b0;
    ack_force = 1'b1;
    step();
    chk("reset_ack_in_reset", outs(), 64'h0);
    step();
    reset_n = 1'b1;
    chk("reset_ack_idle", outs(), 64'h0);
    step();
    chk("restart_req", {50'b0, mem_rd, mem_addr, ir_valid}, {50'b0, 1'b1, 12'h000, 1'b0});
    ack_force = 1'b0;
    ack_auto  = 1'b1;
    step();
    chk("restart_ir", {35'b0, ir_valid, ir_pc, ir}, {35'b0, 1'b1, 12'h000, 16'h0010});

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 12'h005;
    step();
    redirect = 1'b0;
`ifdef MCU0_FETCH_ALIGN_CHECK_EN
    chk("fault_set", {61'b0, fault, mem_rd, ir_valid}, {61'b0, 1'b1, 1'b0, 1'b0});
    step();
    step();
    redirect    = 1'b1;
    redirect_pc = 12'h008;
    step();
    redirect = 1'b0;
    step();
    chk("fault_hold", {48'b0, fault, mem_rd, ir_valid, mem_addr}, {48'b0, 1'b1, 1'b0, 1'b0, 12'h000});
    do_reset();
    chk("fault_cleared", outs(), 64'h0);
`else
    chk("misaligned_forced", {50'b0, fault, mem_rd, mem_addr}, {50'b0, 1'b0, 1'b1, 12'h004});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
